// File: rtl/env_pkg.sv
// ----------------------------------------------------------------------------
// env_pkg
// Shared types and constants for the envelope generator.
//   env_state_t  : 3-bit envelope state encoding (IDLE..RELEASE)
//   LEVEL_W      : envelope level width
//   LEVEL_MAX    : full-scale envelope level
//   SAMPLE_W     : audio sample width
//   release_dec(): per-tick RELEASE decrement derived from the 4-bit rate
// ----------------------------------------------------------------------------
package env_pkg;

    localparam int unsigned LEVEL_W   = 10;
    localparam int unsigned LEVEL_MAX = 1023;
    localparam int unsigned SAMPLE_W  = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } env_state_t;

    // rate*4+3 is just the rate with two ones appended (range 3..63).
    function automatic logic [6:0] release_dec(input logic [3:0] rate);
        return {1'b0, rate, 2'b11};
    endfunction

endpackage

// File: rtl/env_prescaler.sv
// ----------------------------------------------------------------------------
// env_prescaler
// Divides the master clock down to a one-cycle envelope tick.
//   phiM : master clock
//   IC   : asynchronous active-high reset
//   tick : high for the single cycle in which the count equals TICK_DIV-1
// ----------------------------------------------------------------------------
module env_prescaler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic phiM,
    input  logic IC,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/env_gen.sv
// ----------------------------------------------------------------------------
// env_gen
// ADSR envelope generator with sample multiplier.
//   phiM             : master clock
//   IC               : asynchronous active-high reset
//   key_on           : note gate level
//   attack_rate      : ATTACK increment per tick (0 = hold)
//   decay_rate       : DECAY decrement per tick (0 = hold)
//   sustain_lvl      : sustain target in units of 64
//   release_rate     : RELEASE decrement code (rate*4+3 per tick)
//   sample_in/valid  : signed oscillator sample and its strobe
//   sample_out/valid : enveloped sample, one cycle after sample_valid
//   env_level        : current envelope level 0..1023
//   env_state        : current envelope state encoding
// ----------------------------------------------------------------------------
module env_gen
    import env_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic                       phiM,
    input  logic                       IC,
    input  logic                       key_on,
    input  logic [4:0]                 attack_rate,
    input  logic [4:0]                 decay_rate,
    input  logic [3:0]                 sustain_lvl,
    input  logic [3:0]                 release_rate,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic [LEVEL_W-1:0]         env_level,
    output logic [2:0]                 env_state
);

    logic                       w_tick;
    logic                       w_rise;
    logic                       w_fall;
    logic [LEVEL_W:0]           w_att_sum;
    logic [LEVEL_W-1:0]         w_target;
    logic signed [LEVEL_W:0]    w_dec_diff;
    logic signed [LEVEL_W:0]    w_rel_diff;
    logic signed [26:0]         w_product;
    logic                       w_unused_prod;

    logic                       r_key_q;
    env_state_t                 r_state;
    logic [LEVEL_W-1:0]         r_level;
    logic signed [SAMPLE_W-1:0] r_sample;
    logic                       r_valid;

    env_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .phiM (phiM),
        .IC   (IC),
        .tick (w_tick)
    );

    assign w_rise = key_on & ~r_key_q;
    assign w_fall = ~key_on & r_key_q;

    // One extra bit so overflow past full scale and underflow below zero are visible.
    assign w_att_sum  = {1'b0, r_level} + {6'b0, attack_rate};
    assign w_target   = {sustain_lvl, 6'b0};
    assign w_dec_diff = $signed({1'b0, r_level}) - $signed({6'b0, decay_rate});
    assign w_rel_diff = $signed({1'b0, r_level}) - $signed({4'b0, release_dec(release_rate)});

    // Level is zero-extended so it multiplies as a non-negative signed value.
    assign w_product     = sample_in * $signed({1'b0, r_level});
    assign w_unused_prod = ^{w_product[26], w_product[9:0]};

    // Envelope FSM; an accepted key edge takes priority over the tick update.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            r_key_q <= 1'b0;
            r_state <= StIdle;
            r_level <= '0;
        end else begin
            r_key_q <= key_on;
            if (w_rise) begin
                r_state <= StAttack;
            end else if (w_fall && (r_state == StAttack || r_state == StDecay ||
                                    r_state == StSustain)) begin
                r_state <= StRelease;
            end else if (w_tick) begin
                unique case (r_state)
                    StIdle: begin
                        r_level <= '0;
                    end
                    StAttack: begin
                        if (w_att_sum >= (LEVEL_W + 1)'(LEVEL_MAX)) begin
                            r_level <= LEVEL_W'(LEVEL_MAX);
                            r_state <= StDecay;
                        end else begin
                            r_level <= w_att_sum[LEVEL_W-1:0];
                        end
                    end
                    StDecay: begin
                        if (r_level <= w_target) begin
                            r_state <= StSustain;
                        end else if (w_dec_diff <= $signed({1'b0, w_target})) begin
                            r_level <= w_target;
                            r_state <= StSustain;
                        end else begin
                            r_level <= w_dec_diff[LEVEL_W-1:0];
                        end
                    end
                    StSustain: begin
                        r_level <= r_level;
                    end
                    StRelease: begin
                        if (w_rel_diff[LEVEL_W] || (w_rel_diff == '0)) begin
                            r_level <= '0;
                            r_state <= StIdle;
                        end else begin
                            r_level <= w_rel_diff[LEVEL_W-1:0];
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_level <= '0;
                    end
                endcase
            end
        end
    end

    // Sample path: capture the scaled product on each valid, hold otherwise.
    always_ff @(posedge phiM or posedge IC) begin
        if (IC) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= sample_valid;
            if (sample_valid) begin
                r_sample <= w_product[25:10];
            end
        end
    end

    // Muting on IDLE also hides any sample held over from the RELEASE tail.
    assign sample_out       = (r_state == StIdle) ? '0 : r_sample;
    assign sample_out_valid = r_valid;
    assign env_level        = r_level;
    assign env_state        = r_state;

endmodule

// File: tb/tb_env_gen.sv
module tb_env_gen;

    localparam int TD = 4;

    logic              phiM = 1'b0;
    logic              IC;
    logic              key_on;
    logic [4:0]        attack_rate;
    logic [4:0]        decay_rate;
    logic [3:0]        sustain_lvl;
    logic [3:0]        release_rate;
    logic signed [15:0] sample_in;
    logic              sample_valid;
    logic signed [15:0] sample_out;
    logic              sample_out_valid;
    logic [9:0]        env_level;
    logic [2:0]        env_state;

    always #5 phiM = ~phiM;

    env_gen #(
        .TICK_DIV (TD)
    ) dut (
        .phiM             (phiM),
        .IC               (IC),
        .key_on           (key_on),
        .attack_rate      (attack_rate),
        .decay_rate       (decay_rate),
        .sustain_lvl      (sustain_lvl),
        .release_rate     (release_rate),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .env_level        (env_level),
        .env_state        (env_state)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_print = 0;

    // Reference model: states 0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE.
    int m_cnt, m_kq, m_state, m_level, m_out, m_vld;

    typedef struct {
        logic signed [15:0] smp;
        logic signed [15:0] exp;
    } dp_vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_kq = 0; m_state = 0; m_level = 0; m_out = 0; m_vld = 0;
    endtask

    task automatic model_edge();
        bit tick, rise, fall;
        int tgt;
        tick = (m_cnt == TD - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        rise = key_on && (m_kq == 0);
        fall = !key_on && (m_kq == 1);
        if (sample_valid) m_out = (int'(sample_in) * m_level) >>> 10;
        m_vld = sample_valid ? 1 : 0;
        if (rise) begin
            m_state = 1;
        end else if (fall && m_state >= 1 && m_state <= 3) begin
            m_state = 4;
        end else if (tick) begin
            case (m_state)
                1: begin
                    m_level = m_level + int'(attack_rate);
                    if (m_level >= 1023) begin m_level = 1023; m_state = 2; end
                end
                2: begin
                    tgt = int'(sustain_lvl) * 64;
                    if (m_level <= tgt) m_state = 3;
                    else begin
                        m_level = m_level - int'(decay_rate);
                        if (m_level <= tgt) begin m_level = tgt; m_state = 3; end
                    end
                end
                4: begin
                    m_level = m_level - (int'(release_rate) * 4 + 3);
                    if (m_level <= 0) begin m_level = 0; m_state = 0; end
                end
                default: ;
            endcase
        end
        m_kq = key_on ? 1 : 0;
    endtask

    // One clock: advance model, then compare every output 1 time unit after the edge.
    task automatic cycle();
        int exp_out;
        @(posedge phiM);
        if (IC) model_reset();
        else model_edge();
        #1;
        exp_out = (m_state == 0) ? 0 : m_out;
        n_cmp++;
        if (int'(env_state) != m_state || int'(env_level) != m_level ||
            int'(sample_out_valid) != m_vld || int'(sample_out) != exp_out) begin
            n_fail++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL cycle_model: got st=%0d lvl=%0d out=%0d vld=%0d, expected st=%0d lvl=%0d out=%0d vld=%0d (t=%0t)",
                         env_state, env_level, sample_out, sample_out_valid,
                         m_state, m_level, exp_out, m_vld, $time);
            end
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int k = 0;
        while (int'(env_state) != s && k < budget) begin cycle(); k++; end
        check(name, int'(env_state), s);
    endtask

    task automatic count_ticks(input int s, input int budget, output int nt, output int first);
        int k = 0;
        int prev = int'(env_level);
        nt = 0; first = -1;
        while (int'(env_state) == s && k < budget) begin
            cycle(); k++;
            if (int'(env_level) != prev) begin
                nt++;
                if (first < 0) first = int'(env_level);
                prev = int'(env_level);
            end
        end
    endtask

    initial begin
        dp_vec_t dp[6];
        int nt, first, k;

        dp[0] = '{smp: 16'sh4000, exp: 16'sh2000};
        dp[1] = '{smp: 16'sh8000, exp: 16'shC000};
        dp[2] = '{smp: 16'sh7FFF, exp: 16'sh3FFF};
        dp[3] = '{smp: 16'shFFFF, exp: 16'shFFFF};
        dp[4] = '{smp: 16'sh0001, exp: 16'sh0000};
        dp[5] = '{smp: 16'sh1234, exp: 16'sh091A};

        IC = 1'b1; key_on = 1'b0; attack_rate = '0; decay_rate = '0;
        sustain_lvl = '0; release_rate = '0; sample_in = '0; sample_valid = 1'b0;
        model_reset();
        #12;
        check("rst_state", int'(env_state), 0);
        check("rst_level", int'(env_level), 0);
        check("rst_out", int'(sample_out), 0);
        check("rst_valid", int'(sample_out_valid), 0);
        IC = 1'b0;
        repeat (2) cycle();

        // Attack 31/tick from 0 reaches 1023 in 33 ticks.
        attack_rate = 5'd31; decay_rate = 5'd7; sustain_lvl = 4'd8; release_rate = 4'd0;
        key_on = 1'b1;
        cycle();
        check("att_enter", int'(env_state), 1);
        check("att_keep0", int'(env_level), 0);
        count_ticks(1, 400, nt, first);
        check("att_first", first, 31);
        check("att_ticks", nt, 33);
        check("att_peak", int'(env_level), 1023);
        check("att_to_decay", int'(env_state), 2);

        // Decay 7/tick clamps at 8*64 = 512 and holds.
        wait_state(3, 600, "dec_to_sus");
        check("sus_level", int'(env_level), 512);
        repeat (20 * TD) cycle();
        check("sus_hold_lvl", int'(env_level), 512);
        check("sus_hold_st", int'(env_state), 3);

        // Datapath at level 512 (half scale).
        foreach (dp[i]) begin
            sample_in = dp[i].smp; sample_valid = 1'b1;
            cycle();
            check("dp_out", int'(sample_out), int'(dp[i].exp));
            check("dp_valid", int'(sample_out_valid), 1);
            sample_valid = 1'b0; sample_in = 16'($urandom);
            cycle();
            check("dp_hold", int'(sample_out), int'(dp[i].exp));
            check("dp_valid_lo", int'(sample_out_valid), 0);
        end

        // Release 3/tick from 512 needs 171 ticks to hit 0.
        key_on = 1'b0;
        cycle();
        check("rel_enter", int'(env_state), 4);
        check("rel_keep", int'(env_level), 512);
        count_ticks(4, 2000, nt, first);
        check("rel_ticks", nt, 171);
        check("rel_zero", int'(env_level), 0);
        check("rel_idle", int'(env_state), 0);
        sample_in = 16'sh4000; sample_valid = 1'b1;
        cycle();
        check("idle_out", int'(sample_out), 0);
        check("idle_valid", int'(sample_out_valid), 1);
        sample_valid = 1'b0;

        // Retrigger from RELEASE at 300, rise coincident with a tick.
        sustain_lvl = 4'd6; release_rate = 4'd1;
        key_on = 1'b1;
        wait_state(2, 300, "re_att_done");
        wait_state(3, 800, "re_dec_done");
        check("re_sus384", int'(env_level), 384);
        key_on = 1'b0;
        cycle();
        k = 0;
        while (int'(env_level) != 300 && k < 200) begin cycle(); k++; end
        check("re_rel300", int'(env_level), 300);
        repeat (TD - 1) cycle();
        key_on = 1'b1;
        cycle();
        check("re_rise_st", int'(env_state), 1);
        check("re_rise_lvl", int'(env_level), 300);
        repeat (TD) cycle();
        check("re_climb", int'(env_level), 331);

        // Asynchronous reset mid-ATTACK.
        repeat (5) cycle();
        #3;
        IC = 1'b1;
        #1;
        model_reset();
        check("arst_state", int'(env_state), 0);
        check("arst_level", int'(env_level), 0);
        check("arst_out", int'(sample_out), 0);
        check("arst_valid", int'(sample_out_valid), 0);
        cycle(); cycle();
        IC = 1'b0;
        cycle();
        check("post_rst_st", int'(env_state), 1);
        check("post_rst_lvl", int'(env_level), 0);
        k = 0;
        while (int'(env_level) == 0 && k < 20) begin cycle(); k++; end
        check("post_rst_step", int'(env_level), 31);

        // Randomised run against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 59) == 0) key_on = ~key_on;
            if ($urandom_range(0, 15) == 0) attack_rate = 5'($urandom);
            if ($urandom_range(0, 15) == 0) decay_rate = 5'($urandom);
            if ($urandom_range(0, 15) == 0) sustain_lvl = 4'($urandom);
            if ($urandom_range(0, 15) == 0) release_rate = 4'($urandom);
            sample_in = 16'($urandom);
            sample_valid = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/env_gen.md
ENV_GEN -- requirements
Module: env_gen

Interface
REQ-001 Parameter: TICK_DIV, default 1000, phiM cycles per envelope tick (legal range 2..65535).
REQ-002 phiM  in  1  master clock; all state updates on its rising edge.
REQ-003 IC  in  1  reset; asynchronous, active-high.
REQ-004 key_on  in  1  note gate level; high = key held.
REQ-005 attack_rate  in  5  level increment per tick in ATTACK; 0 = hold.
REQ-006 decay_rate  in  5  level decrement per tick in DECAY; 0 = hold.
REQ-007 sustain_lvl  in  4  sustain target = sustain_lvl*64.
REQ-008 release_rate  in  4  RELEASE decrement per tick = release_rate*4+3 (range 3..63).
REQ-009 sample_in  in  16  signed two's-complement oscillator sample from phase_gen.
REQ-010 sample_valid  in  1  sample_in qualifier, single-cycle pulses.
REQ-011 sample_out  out  16  signed enveloped sample.
REQ-012 sample_out_valid  out  1  sample_out qualifier.
REQ-013 env_level  out  10  current envelope level, 0..1023.
REQ-014 env_state  out  3  current state encoding (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4).

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 and wraps; tick is asserted for the one cycle in which the count equals TICK_DIV-1.
REQ-016 key_on is registered into key_q; rise = key_on & ~key_q; fall = ~key_on & key_q.
REQ-017 rise in any state: next state is ATTACK and level is kept (no reset to 0).
REQ-018 fall in ATTACK, DECAY or SUSTAIN: next state is RELEASE and level is kept; fall in IDLE is ignored.
REQ-019 When an edge and a tick occur in the same cycle, the transition is taken and the level is not updated that cycle.
REQ-020 ATTACK on tick: level = min(level+attack_rate, 1023), computed at 11-bit width; when the result is 1023, next state is DECAY.
REQ-021 DECAY on tick: level = max(level-decay_rate, target), computed at 11-bit signed width; when the result equals target, next state is SUSTAIN; if level <= target on entry, go to SUSTAIN on the first tick with level unchanged.
REQ-022 SUSTAIN: level is held; there is no tick-driven transition.
REQ-023 RELEASE on tick: level = max(level-release_dec, 0); when the result is 0, next state is IDLE.
REQ-024 IDLE: level is 0 and held.
REQ-025 Rate/level inputs are sampled on each tick and may change at any time.
REQ-026 Datapath: product = sample_in (signed 16) * {1'b0, env_level} (signed 11); sample_out = product[25:10]. Latency is 1 cycle: sample_out_valid is asserted the cycle after sample_valid. Level 1023 gives sample*1023/1024.
REQ-027 sample_out is forced to 0 while in IDLE; sample_out_valid still follows sample_valid.
REQ-028 sample_out holds its value between valid pulses.

Reset
REQ-029 While IC is high: state=IDLE, level=0, prescaler=0, key_q=0, sample_out=0, sample_out_valid=0, env_state=0, env_level=0; outputs clear asynchronously.
REQ-030 On IC deassertion with key_on already high, the first clock edge detects a rise and enters ATTACK.

Structure
REQ-031 Package env_pkg holds env_state_t (enum, 3-bit), LEVEL_W=10, LEVEL_MAX=1023 and SAMPLE_W=16.
REQ-032 The prescaler is sub-module env_prescaler (ports phiM, IC, tick; parameter TICK_DIV); the FSM and multiplier stay in env_gen.

Verification (TICK_DIV=4)
REQ-033 Attack: attack_rate=31, key_on 0->1 -> ATTACK, level 31,62,...; after 33 ticks level=1023, then DECAY.
REQ-034 Decay: decay_rate=7, sustain_lvl=8, starting at level 1023 -> level decrements by 7 per tick, clamps at 512, enters SUSTAIN, holds 512 over 20 ticks.
REQ-035 Release: release_rate=0, key_on 1->0 at level 512 -> RELEASE, decrement 3 per tick, level 0 after 171 ticks, then IDLE.
REQ-036 Retrigger: key_on rise in RELEASE at level 300 -> ATTACK continuing upward from 300; a rise coincident with a tick leaves level unchanged that cycle.
REQ-037 Datapath: level=512; sample_in 0x4000 -> sample_out 0x2000; sample_in 0x8000 -> 0xC000; each with valid 1 cycle later; in IDLE, sample_out=0.
REQ-038 Reset mid-ATTACK: assert IC between clock edges -> all outputs 0 immediately; after release with key_on=1 -> ATTACK from 0.
